// File: rtl/macc_pkg.sv
// rtl/macc_pkg.sv - shared widths, signed range helpers and stage sideband for macc_lanes
package macc_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } stage_t;

  function automatic int sum_width(input int adw, input int bdw, input int lanes);
    return adw + bdw + $clog2(lanes);
  endfunction

  // Callers truncate to their own width: w bits of these give the signed extremes.
  function automatic logic [127:0] smax(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] smin(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/macc_lanes_if.sv
// rtl/macc_lanes_if.sv - A/B operand streams and result stream of macc_lanes
interface macc_lanes_if #(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int ODW   = 48,
  parameter int LANES = 4
);
  logic [LANES*ADW-1:0] s_axis_atdata;
  logic                 s_axis_atvalid;
  logic                 s_axis_atready;
  logic                 s_axis_atlast;
  logic [LANES*BDW-1:0] s_axis_btdata;
  logic                 s_axis_btvalid;
  logic                 s_axis_btready;
  logic [ODW-1:0]       m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tuser;

  modport master (
    output s_axis_atdata, s_axis_atvalid, s_axis_atlast,
    output s_axis_btdata, s_axis_btvalid, m_axis_tready,
    input  s_axis_atready, s_axis_btready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );

  modport slave (
    input  s_axis_atdata, s_axis_atvalid, s_axis_atlast,
    input  s_axis_btdata, s_axis_btvalid, m_axis_tready,
    output s_axis_atready, s_axis_btready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );
endinterface

// File: rtl/macc_lane_tree.sv
// rtl/macc_lane_tree.sv - S1 per-lane signed multipliers and S2 sign-extended adder tree
module macc_lane_tree
  import macc_pkg::*;
#(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int LANES = 4,
  localparam int PW   = ADW + BDW,
  localparam int SW   = sum_width(ADW, BDW, LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  stage_t               in_stage,
  input  logic [LANES*ADW-1:0] a,
  input  logic [LANES*BDW-1:0] b,
  output stage_t               out_stage,
  output logic signed [SW-1:0] sum
);

  logic signed [PW-1:0] prod [LANES];
  stage_t               s1;
  logic signed [SW-1:0] sum_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
    end else if (en) begin
      s1 <= in_stage;
      for (int i = 0; i < LANES; i++)
        prod[i] <= PW'($signed(a[i*ADW +: ADW])) * PW'($signed(b[i*BDW +: BDW]));
    end
  end

  // SW carries $clog2(LANES) guard bits, so this sum cannot wrap.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + SW'(prod[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_stage <= '0;
      sum       <= '0;
    end else if (en) begin
      out_stage <= s1;
      sum       <= sum_c;
    end
  end

endmodule

// File: rtl/macc_lanes.sv
// rtl/macc_lanes.sv - multi-lane frame MACC top; MACC_LANES_SAT_EN selects a saturating accumulator
module macc_lanes
  import macc_pkg::*;
#(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int ODW   = 48,
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  macc_lanes_if.slave bus
);

  localparam int SW = sum_width(ADW, BDW, LANES);

  if (LANES < 1) begin : g_bad_lanes
    $error("macc_lanes: LANES must be >= 1");
  end
  if (ODW < SW) begin : g_bad_odw
    $error("macc_lanes: ODW must be >= ADW+BDW+clog2(LANES)");
  end

  logic               en, accept;
  stage_t             in_stage, s2;
  logic signed [SW-1:0]  sum2;
  logic signed [ODW-1:0] acc, sum_ext, add, acc_nxt, r3_data, out_data;
  logic               flag, ovf, flag_nxt, v3, r3_user, out_valid, out_user;

  assign en     = !out_valid || bus.m_axis_tready;
  assign accept = bus.s_axis_atvalid && bus.s_axis_btvalid && en;

  // Readies are forced low while reset is asserted, not just after it.
  assign bus.s_axis_atready = !rst && en && bus.s_axis_btvalid;
  assign bus.s_axis_btready = !rst && en && bus.s_axis_atvalid;

  assign in_stage.valid = accept;
  assign in_stage.last  = bus.s_axis_atlast;

  macc_lane_tree #(.ADW(ADW), .BDW(BDW), .LANES(LANES)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_stage  (in_stage),
    .a         (bus.s_axis_atdata),
    .b         (bus.s_axis_btdata),
    .out_stage (s2),
    .sum       (sum2)
  );

`ifdef MACC_LANES_SAT_EN
  localparam logic signed [ODW-1:0] ACC_MAX = ODW'(smax(ODW));
  localparam logic signed [ODW-1:0] ACC_MIN = ODW'(smin(ODW));
`endif

  always_comb begin
    sum_ext  = ODW'(sum2);
    add      = acc + sum_ext;
    ovf      = (acc[ODW-1] == sum_ext[ODW-1]) && (add[ODW-1] != acc[ODW-1]);
    flag_nxt = flag || ovf;
`ifdef MACC_LANES_SAT_EN
    // Once clamped, the accumulator stays pinned for the rest of the frame.
    if (flag)     acc_nxt = acc;
    else if (ovf) acc_nxt = acc[ODW-1] ? ACC_MIN : ACC_MAX;
    else          acc_nxt = add;
`else
    acc_nxt = add;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      flag    <= 1'b0;
      v3      <= 1'b0;
      r3_data <= '0;
      r3_user <= 1'b0;
    end else if (en) begin
      v3 <= s2.valid && s2.last;
      if (s2.valid) begin
        if (s2.last) begin
          r3_data <= acc_nxt;
          r3_user <= flag_nxt;
          acc     <= '0;
          flag    <= 1'b0;
        end else begin
          acc  <= acc_nxt;
          flag <= flag_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
    end else if (en) begin
      out_valid <= v3;
      if (v3) begin
        out_data <= r3_data;
        out_user <= r3_user;
      end
    end
  end

  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tuser  = out_user;

endmodule

// File: tb/tb_macc_lanes.sv
// tb/tb_macc_lanes.sv - directed self-checking bench for macc_lanes (LANES=4, ADW=24, BDW=18, ODW=48)
module tb_macc_lanes;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;

  logic [47:0] res_q [$];
  logic        usr_q [$];
  int          cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  macc_lanes_if #(.ADW(24), .BDW(18), .ODW(48), .LANES(4)) bus ();

  macc_lanes #(.ADW(24), .BDW(18), .ODW(48), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    #2;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      res_q.push_back(bus.m_axis_tdata);
      usr_q.push_back(bus.m_axis_tuser);
      cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pa(input int l0, input int l1, input int l2, input int l3);
    return {24'(l3), 24'(l2), 24'(l1), 24'(l0)};
  endfunction

  function automatic logic [71:0] pb(input int l0, input int l1, input int l2, input int l3);
    return {18'(l3), 18'(l2), 18'(l1), 18'(l0)};
  endfunction

  task automatic beat(input logic [95:0] a, input logic [71:0] b, input logic last);
    int n;
    @(negedge clk);
    bus.s_axis_atdata  = a;
    bus.s_axis_btdata  = b;
    bus.s_axis_atlast  = last;
    bus.s_axis_atvalid = 1'b1;
    bus.s_axis_btvalid = 1'b1;
    #1;
    n = 0;
    while (!(bus.s_axis_atready && bus.s_axis_btready) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40) chk("accept_timeout", 64'(n), 64'd0);
    acc_cyc = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_axis_atvalid = 1'b0;
    bus.s_axis_btvalid = 1'b0;
    bus.s_axis_atlast  = 1'b0;
  endtask

  task automatic wait_res(input int n, input string tag);
    int k;
    k = 0;
    while (res_q.size() < n && k < 60) begin
      @(negedge clk); #3;
      k++;
    end
    chk(tag, 64'(res_q.size() >= n), 64'd1);
  endtask

  task automatic clear_q();
    res_q.delete();
    usr_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    bus.s_axis_atdata  = '0;
    bus.s_axis_btdata  = '0;
    bus.s_axis_atlast  = 1'b0;
    bus.s_axis_atvalid = 1'b1;
    bus.s_axis_btvalid = 1'b1;
    bus.m_axis_tready  = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_atready", 64'(bus.s_axis_atready), 64'd0);
    chk("rst_btready", 64'(bus.s_axis_btready), 64'd0);
    chk("rst_tvalid",  64'(bus.m_axis_tvalid),  64'd0);
    chk("rst_tdata",   64'(bus.m_axis_tdata),   64'd0);
    chk("rst_tuser",   64'(bus.m_axis_tuser),   64'd0);
    bus.s_axis_atvalid = 1'b0;
    bus.s_axis_btvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single-beat frame: 1*5+2*6+3*7+4*8 = 70
    beat(pa(1, 2, 3, 4), pb(5, 6, 7, 8), 1'b1);
    idle();
    wait_res(1, "t1_result_seen");
    chk("t1_tdata",   64'(res_q[0]), 64'd70);
    chk("t1_tuser",   64'(usr_q[0]), 64'd0);
    chk("t1_latency", 64'(cyc_q[0] - acc_cyc), 64'd3);
    @(negedge clk); #3;
    chk("t1_one_cycle", 64'(bus.m_axis_tvalid), 64'd0);
    clear_q();

    // 3-beat frame of -4 per beat, then a 1-beat frame of 4*6
    beat(pa(-1, -1, -1, -1), pb(1, 1, 1, 1), 1'b0);
    beat(pa(-1, -1, -1, -1), pb(1, 1, 1, 1), 1'b0);
    beat(pa(-1, -1, -1, -1), pb(1, 1, 1, 1), 1'b1);
    beat(pa(2, 2, 2, 2), pb(3, 3, 3, 3), 1'b1);
    idle();
    wait_res(2, "t2_results_seen");
    chk("t2_tdata0",  64'(res_q[0]), 64'(48'hFFFF_FFFF_FFF4));
    chk("t2_tdata1",  64'(res_q[1]), 64'd24);
    chk("t2_tuser0",  64'(usr_q[0]), 64'd0);
    chk("t2_tuser1",  64'(usr_q[1]), 64'd0);
    chk("t2_b2b_gap", 64'(cyc_q[1] - cyc_q[0]), 64'd1);
    repeat (3) @(negedge clk);
    clear_q();

    // backpressure: result 8 stalls for 5 cycles while a new beat waits
    bus.m_axis_tready = 1'b0;
    beat(pa(1, 1, 1, 1), pb(2, 2, 2, 2), 1'b1);
    idle();
    begin
      int k;
      k = 0;
      while (!bus.m_axis_tvalid && k < 20) begin
        @(negedge clk); #1;
        k++;
      end
      chk("t3_tvalid_seen", 64'(bus.m_axis_tvalid), 64'd1);
    end
    bus.s_axis_atdata  = pa(1, 1, 1, 1);
    bus.s_axis_btdata  = pb(1, 1, 1, 1);
    bus.s_axis_atlast  = 1'b1;
    bus.s_axis_atvalid = 1'b1;
    bus.s_axis_btvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_atready_low", 64'(bus.s_axis_atready), 64'd0);
      chk("t3_btready_low", 64'(bus.s_axis_btready), 64'd0);
      chk("t3_tdata_hold",  64'(bus.m_axis_tdata),   64'd8);
      @(negedge clk);
    end
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    bus.s_axis_atvalid = 1'b0;
    bus.s_axis_btvalid = 1'b0;
    bus.s_axis_atlast  = 1'b0;
    wait_res(2, "t3_results_seen");
    repeat (6) @(negedge clk);
    chk("t3_count",  64'(res_q.size()), 64'd2);
    chk("t3_tdata0", 64'(res_q[0]), 64'd8);
    chk("t3_tdata1", 64'(res_q[1]), 64'd4);
    clear_q();

    // A valid alone must not be accepted
    @(negedge clk);
    bus.s_axis_atdata  = pa(1, 2, 3, 4);
    bus.s_axis_btdata  = pb(5, 6, 7, 8);
    bus.s_axis_atlast  = 1'b1;
    bus.s_axis_atvalid = 1'b1;
    bus.s_axis_btvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_atready_low", 64'(bus.s_axis_atready), 64'd0);
      chk("t4_btready_hi",  64'(bus.s_axis_btready), 64'd1);
      @(negedge clk);
    end
    bus.s_axis_btvalid = 1'b1;
    #1;
    chk("t4_atready_hi", 64'(bus.s_axis_atready), 64'd1);
    idle();
    wait_res(1, "t4_result_seen");
    repeat (4) @(negedge clk);
    chk("t4_count", 64'(res_q.size()), 64'd1);
    chk("t4_tdata", 64'(res_q[0]), 64'd70);
    clear_q();

    // 32 beats of 4 * 2^40 -> exactly 2^47, one past the positive limit
    for (int i = 0; i < 32; i++)
      beat(pa(-8388608, -8388608, -8388608, -8388608),
           pb(-131072, -131072, -131072, -131072), 1'(i == 31));
    idle();
    wait_res(1, "t5_result_seen");
`ifdef MACC_LANES_SAT_EN
    chk("t5_tdata_sat", 64'(res_q[0]), 64'(48'h7FFF_FFFF_FFFF));
`else
    chk("t5_tdata_wrap", 64'(res_q[0]), 64'(48'h8000_0000_0000));
`endif
    chk("t5_tuser", 64'(usr_q[0]), 64'd1);
    repeat (3) @(negedge clk);
    clear_q();

    // reset mid-frame with beats in flight
    beat(pa(5, 5, 5, 5), pb(5, 5, 5, 5), 1'b0);
    beat(pa(5, 5, 5, 5), pb(5, 5, 5, 5), 1'b0);
    @(negedge clk);
    bus.s_axis_atvalid = 1'b0;
    bus.s_axis_btvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beat(pa(1, 1, 1, 1), pb(1, 1, 1, 1), 1'b1);
    idle();
    wait_res(1, "t6_result_seen");
    repeat (8) @(negedge clk);
    chk("t6_count", 64'(res_q.size()), 64'd1);
    chk("t6_tdata", 64'(res_q[0]), 64'd4);
    chk("t6_tuser", 64'(usr_q[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
